// File: rtl/comb_truth_scan_if.sv
// Control/result bundle for the comb truth-table scanner.
// The master side requests scans; the slave side is the scanner itself.
interface comb_truth_scan_if;
  logic       start;
  logic [7:0] expected;
  logic       busy;
  logic       done;
  logic [7:0] truth_table;
  logic       match;

  modport master (output start, expected, input busy, done, truth_table, match);
  modport slave  (input start, expected, output busy, done, truth_table, match);
endinterface

// File: rtl/comb_truth_scan.sv
// Steps {A,B,C} through all eight vectors, samples Q after a settle window
// and assembles/compares the resulting truth table.
//
// state    | meaning
// ---------+----------------------------------------------
// S_IDLE   | waiting for start; idx held at 0
// S_SETTLE | vector idx on A/B/C, counting SETTLE cycles
// S_SAMPLE | one cycle: capture Q into scr[idx], advance
module comb_truth_scan #(
  parameter int unsigned SETTLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  comb_truth_scan_if.slave   bus,
  output logic               A,
  output logic               B,
  output logic               C,
  input  logic               Q
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      idx;
  logic [CW-1:0]   cnt;
  logic [7:0]      scr;
  logic [7:0]      scr_nxt;

  // scr[idx] is always clear at sample time, so OR-ing in Q sets exactly that bit
  assign scr_nxt = scr | (8'(Q) << idx);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == CW'(SETTLE - 1)) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (idx == 3'd7) ? S_IDLE : S_SETTLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx             <= 3'd0;
      cnt             <= '0;
      scr             <= 8'h00;
      bus.done        <= 1'b0;
      bus.truth_table <= 8'h00;
      bus.match       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            idx <= 3'd0;
            cnt <= '0;
            scr <= 8'h00;
          end
        end
        S_SETTLE: cnt <= cnt + CW'(1);
        S_SAMPLE: begin
          scr <= scr_nxt;
          cnt <= '0;
          if (idx == 3'd7) begin
            bus.truth_table <= scr_nxt;
            bus.match       <= (scr_nxt == bus.expected);
            bus.done        <= 1'b1;
            idx             <= 3'd0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign {A, B, C} = idx;
  assign bus.busy  = (state != S_IDLE);

endmodule

// File: tb/tb_comb_truth_scan.sv
// Bench for comb_truth_scan: behavioural comb model on Q, scoreboard of
// expected tables pushed at each start and popped at each done.
module tb_comb_truth_scan;
  localparam int SETTLE = 4;
  localparam int VLEN   = SETTLE + 1;
  localparam int SCAN   = 8 * VLEN;

  logic clk = 1'b0;
  logic rst;
  logic A, B, C, Q;
  logic and_mode;

  comb_truth_scan_if bus ();

  comb_truth_scan #(.SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .A   (A),
    .B   (B),
    .C   (C),
    .Q   (Q)
  );

  always #5 clk = ~clk;

  // comb under test: majority, or 3-input AND for the back-to-back case
  assign Q = and_mode ? (A & B & C) : ((A & B) | (A & C) | (B & C));

  typedef struct packed {
    logic [7:0] tbl;
    logic       m;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] last_tbl;
  logic       last_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, req, $time);
    end
  endtask

  function automatic logic [7:0] model_tbl(input logic am);
    logic [7:0] t;
    logic a, b, c;
    t = 8'h00;
    for (int i = 0; i < 8; i++) begin
      a = i[2]; b = i[1]; c = i[0];
      t[i] = am ? (a & b & c) : ((a & b) | (a & c) | (b & c));
    end
    return t;
  endfunction

  task automatic chk_reset(input string tag);
    chk(tag, 32'({A, B, C, bus.busy, bus.done, bus.match, bus.truth_table}), 32'd0);
  endtask

  // call at a negedge; start is then sampled at the next posedge (edge 0)
  task automatic begin_scan(input logic [7:0] expv);
    exp_t e;
    bus.start    = 1'b1;
    bus.expected = expv;
    e.tbl = model_tbl(and_mode);
    e.m   = (e.tbl == expv);
    exp_q.push_back(e);
  endtask

  // returns at the negedge of the done cycle unless chained is 0
  task automatic run_scan(input int poke_a, input int poke_b, input bit chained);
    exp_t e;
    int   w;
    @(posedge clk);
    for (int k = 0; k < SCAN; k++) begin
      @(negedge clk);
      chk("seq", 32'({bus.busy, bus.done, A, B, C}), 32'({1'b1, 1'b0, 3'(k / VLEN)}));
      chk("hold", 32'({bus.truth_table, bus.match}), 32'({last_tbl, last_m}));
      bus.start = (k == poke_a) || (k == poke_b);
    end
    @(negedge clk);
    bus.start = 1'b0;
    w = 0;
    while (!bus.done && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("done_time", 32'(w), 32'd0);
    chk("busy_in_done", 32'(bus.busy), 32'd0);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("table", 32'(bus.truth_table), 32'(e.tbl));
      chk("match", 32'(bus.match), 32'(e.m));
      last_tbl = e.tbl;
      last_m   = e.m;
    end
    if (!chained) begin
      @(negedge clk);
      chk("done_pulse", 32'({bus.done, bus.busy}), 32'd0);
    end
  endtask

  initial begin
    int dcount;
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.expected = 8'h00;
    and_mode     = 1'b0;
    last_tbl     = 8'h00;
    last_m       = 1'b0;

    // reset with start held: reset wins
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst_vals");
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_nostart", 32'(bus.busy), 32'd0);

    // full scan, matching
    begin_scan(8'hE8);
    run_scan(-1, -1, 1'b0);

    // mismatch
    begin_scan(8'h00);
    run_scan(-1, -1, 1'b0);

    // start pulses while busy, including at the final sample edge
    begin_scan(8'hE8);
    run_scan(10, 39, 1'b0);

    // reset at edge 20 of a scan
    begin_scan(8'hE8);
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 19) rst = 1'b1;
    end
    @(negedge clk);
    chk_reset("rst_mid");
    void'(exp_q.pop_back());
    last_tbl = 8'h00;
    last_m   = 1'b0;
    rst      = 1'b0;
    dcount   = 0;
    for (int k = 0; k < 2 * SCAN; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcount++;
    end
    chk("rst_no_done", 32'(dcount), 32'd0);
    begin_scan(8'hE8);
    run_scan(-1, -1, 1'b0);

    // back-to-back: start held in the done cycle, comb switched to AND3
    begin_scan(8'hE8);
    run_scan(-1, -1, 1'b1);
    and_mode = 1'b1;
    begin_scan(8'h80);
    run_scan(-1, -1, 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
